rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline writeback (the output of the writeback data mux) and a long-latency return unit (multi-cycle ALU ops or slow memory-mapped loads).
- Late results are buffered in a small FIFO. The pipeline gets priority, with a starvation guard that forces a pipeline stall.
- Exports a per-register pending mask so the hazard unit can stall dependent instructions.

Parameters:
- DEPTH, 4, late-result FIFO entries (power of two, 2..8)
- STARVE_LIMIT, 3, consecutive cycles a buffered entry may lose arbitration before the pipeline is stalled

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pipe_we  input  1  pipeline writeback request
- pipe_dst_addr  input  4  pipeline destination register
- pipe_w_data  input  16  pipeline write data (from writeback mux)
- late_vld  input  1  late unit presents a result
- late_dst_addr  input  4  late destination register
- late_data  input  16  late result data
- late_rdy  output  1  FIFO can accept; a transfer occurs when late_vld and late_rdy are both high
- rf_we  output  1  register-file write enable
- rf_dst_addr  output  4  register-file write address
- rf_w_data  output  16  register-file write data
- stall_wb  output  1  pipeline must hold its writeback stage this cycle
- pend_mask  output  16  bit n set while a buffered write to Rn is pending
- hz_err  output  1  sticky: pipeline wrote a register with a pending late write

Behaviour:
- Reset (async, rst=1): FIFO empty, starve counter 0, hz_err 0, rf_we 0, rf_dst_addr 0, rf_w_data 0, stall_wb 0, pend_mask 0.
- late_rdy = !full (combinational). Push occurs on late_vld&&late_rdy.
- Late writes to R0 are accepted (handshake completes) but discarded: not pushed, no pend bit.
- Pipeline writes to R0 are treated as pipe_we=0.
- Arbitration, evaluated each cycle on registered state:
  - Buffer empty: pipe request granted.
  - Buffer non-empty, no pipe request: FIFO head granted and popped.
  - Both requesting and starve count < STARVE_LIMIT: pipe granted; starve count increments.
  - Both requesting and starve count == STARVE_LIMIT: stall_wb=1 (combinational, same cycle); FIFO head granted; pipe write not performed. The pipeline re-presents it next cycle.
  - Starve count clears on every pop and whenever the FIFO is empty.
- Output timing: the granted write is registered. rf_we/rf_dst_addr/rf_w_data are valid one cycle after the grant cycle (latency 1). rf_we=0 when nothing is granted; address and data hold their previous values.
- Bypass: push and pop in the same cycle with an empty FIFO is not allowed. A newly pushed entry is first eligible the following cycle.
- Simultaneous push and pop when full: late_rdy is 0 (it uses pre-pop full), so no push occurs.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- pend_mask: OR over valid entries of one-hot(dst).
  - Bit set the cycle after push.
  - Bit cleared the cycle after pop, unless another valid entry targets the same register.
- hz_err sets when a granted pipe write addresses a register whose pend_mask bit is 1. Cleared only by rst. The write itself still proceeds.
- Reset mid-operation: buffered entries are lost; rf_we drops immediately.

Test Plan:
- Pipe only: pipe_we=1, dst=5, data=0x1234 at cycle 0 -> rf_we=1, addr=5, data=0x1234 at cycle 1; stall_wb never asserts.
- Late only: push dst=7, data=0xBEEF with pipe idle -> pend_mask=0x0080 next cycle; rf write of R7=0xBEEF one cycle after the pop grant; pend_mask returns to 0 after the pop.
- Starvation: buffer one entry (dst=3), hold pipe_we=1 continuously -> 3 pipe writes, then stall_wb=1 for one cycle with R3 written the next cycle; the pipe write is then accepted on re-presentation.
- Full FIFO: push 4 entries while pipe writes continuously -> late_rdy=0 after the 4th push; a 5th late_vld is held off until a pop, and no data is lost; entries drain in push order.
- R0 and hazard: late push to R0 -> no pend bit, no rf_we. Pipe write to R9 while R9 is pending -> hz_err=1 and stays 1 until rst.
- Async reset with 2 entries buffered, asserted between clock edges -> rf_we, pend_mask, late_rdy-related state cleared immediately; late_rdy=1 after rst deasserts.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and a buffered late-result FIFO.
// Latency: write lands one cycle after grant; late_rdy drops when the FIFO is full, stall_wb holds the pipeline on starvation.
module rf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [3:0]  pipe_dst_addr,
    input  logic [15:0] pipe_w_data,
    input  logic        late_vld,
    input  logic [3:0]  late_dst_addr,
    input  logic [15:0] late_data,
    output logic        late_rdy,
    output logic        rf_we,
    output logic [3:0]  rf_dst_addr,
    output logic [15:0] rf_w_data,
    output logic        stall_wb,
    output logic [15:0] pend_mask,
    output logic        hz_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [3:0]       ent_dst  [DEPTH];
    logic [15:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic pipe_req;
    logic grant_pipe;
    logic hz_hit;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        late_rdy = !full;
        // R0 results complete the handshake but are dropped
        push     = late_vld && !full && (late_dst_addr != 4'd0);
        pipe_req = pipe_we && (pipe_dst_addr != 4'd0);
    end

    always_comb begin
        grant_pipe = 1'b0;
        pop        = 1'b0;
        stall_wb   = 1'b0;
        if (empty) begin
            grant_pipe = pipe_req;
        end else if (!pipe_req) begin
            pop = 1'b1;
        end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
            grant_pipe = 1'b1;
        end else begin
            stall_wb = 1'b1;
            pop      = 1'b1;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                pend_mask[ent_dst[i]] = 1'b1;
            end
        end
    end

    assign hz_hit = grant_pipe && pend_mask[pipe_dst_addr];

    always_ff @(posedge clk) begin
        if (push) begin
            ent_dst[wr_ptr]  <= late_dst_addr;
            ent_data[wr_ptr] <= late_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            ent_vld     <= '0;
            hz_err      <= 1'b0;
            rf_we       <= 1'b0;
            rf_dst_addr <= '0;
            rf_w_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + AW'(1);
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + AW'(1);
                ent_vld[rd_ptr] <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (grant_pipe) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            hz_err <= hz_err | hz_hit;

            rf_we <= grant_pipe | pop;
            if (grant_pipe) begin
                rf_dst_addr <= pipe_dst_addr;
                rf_w_data   <= pipe_w_data;
            end else if (pop) begin
                rf_dst_addr <= ent_dst[rd_ptr];
                rf_w_data   <= ent_data[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Vector-table and scoreboard bench for rf_wb_arbiter: pipe-only, late-only, R0, starvation, full FIFO, hazard, async reset.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [3:0]  pipe_dst_addr;
    logic [15:0] pipe_w_data;
    logic        late_vld;
    logic [3:0]  late_dst_addr;
    logic [15:0] late_data;
    logic        late_rdy;
    logic        rf_we;
    logic [3:0]  rf_dst_addr;
    logic [15:0] rf_w_data;
    logic        stall_wb;
    logic [15:0] pend_mask;
    logic        hz_err;

    rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_we       (pipe_we),
        .pipe_dst_addr (pipe_dst_addr),
        .pipe_w_data   (pipe_w_data),
        .late_vld      (late_vld),
        .late_dst_addr (late_dst_addr),
        .late_data     (late_data),
        .late_rdy      (late_rdy),
        .rf_we         (rf_we),
        .rf_dst_addr   (rf_dst_addr),
        .rf_w_data     (rf_w_data),
        .stall_wb      (stall_wb),
        .pend_mask     (pend_mask),
        .hz_err        (hz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [3:0]  pdst;
        logic [15:0] pdat;
        logic        lvld;
        logic [3:0]  ldst;
        logic [15:0] ldat;
        logic        rdy;
        logic        stall;
        logic [15:0] pend;
        logic        hz;
        logic        wr;
        logic [3:0]  wa;
        logic [15:0] wd;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [3:0]  last_a = 4'd0;
    logic [15:0] last_d = 16'd0;
    vec_t        tbl[15];

    function automatic vec_t mk(input logic pwe, input logic [3:0] pdst, input logic [15:0] pdat,
                                input logic lvld, input logic [3:0] ldst, input logic [15:0] ldat,
                                input logic rdy, input logic stall, input logic [15:0] pend,
                                input logic hz, input logic wr, input logic [3:0] wa,
                                input logic [15:0] wd);
        vec_t v;
        v.pwe = pwe; v.pdst = pdst; v.pdat = pdat;
        v.lvld = lvld; v.ldst = ldst; v.ldat = ldat;
        v.rdy = rdy; v.stall = stall; v.pend = pend; v.hz = hz;
        v.wr = wr; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Registered write port: compare against the scoreboard entry labelled with this grant cycle
    task automatic mon();
        logic e;
        e = (exq.size() > 0) && (exq[0].cyc == cyc);
        check("rf_we", rf_we, e);
        if (e) begin
            check("rf_dst_addr", rf_dst_addr, exq[0].a);
            check("rf_w_data", rf_w_data, exq[0].d);
            last_a = exq[0].a;
            last_d = exq[0].d;
            void'(exq.pop_front());
        end else if (!rf_we) begin
            check("rf_addr_hold", rf_dst_addr, last_a);
            check("rf_data_hold", rf_w_data, last_d);
        end
        cyc++;
    endtask

    task automatic apply(input vec_t v);
        wr_t w;
        pipe_we       = v.pwe;
        pipe_dst_addr = v.pdst;
        pipe_w_data   = v.pdat;
        late_vld      = v.lvld;
        late_dst_addr = v.ldst;
        late_data     = v.ldat;
        #1;
        check("late_rdy", late_rdy, v.rdy);
        check("stall_wb", stall_wb, v.stall);
        check("pend_mask", pend_mask, v.pend);
        check("hz_err", hz_err, v.hz);
        if (v.wr) begin
            w.cyc = cyc; w.a = v.wa; w.d = v.wd;
            exq.push_back(w);
        end
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic idle_inputs();
        pipe_we = 1'b0; pipe_dst_addr = 4'd0; pipe_w_data = 16'd0;
        late_vld = 1'b0; late_dst_addr = 4'd0; late_data = 16'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rf_we"}, rf_we, 1'b0);
        check({tag, "_rf_dst_addr"}, rf_dst_addr, 4'd0);
        check({tag, "_rf_w_data"}, rf_w_data, 16'd0);
        check({tag, "_stall_wb"}, stall_wb, 1'b0);
        check({tag, "_pend_mask"}, pend_mask, 16'd0);
        check({tag, "_hz_err"}, hz_err, 1'b0);
        check({tag, "_late_rdy"}, late_rdy, 1'b1);
    endtask

    initial begin
        //            pwe pdst pdat      lvld ldst ldat      rdy stall pend     hz  wr wa  wd
        tbl[0]  = mk(1, 5, 16'h1234,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  1, 5, 16'h1234);
        tbl[1]  = mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);
        tbl[2]  = mk(0, 0, 16'h0000,  1, 7, 16'hBEEF,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);
        tbl[3]  = mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0080, 0,  1, 7, 16'hBEEF);
        tbl[4]  = mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);
        tbl[5]  = mk(0, 0, 16'h0000,  1, 0, 16'hAAAA,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);
        tbl[6]  = mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);
        tbl[7]  = mk(1, 0, 16'h5555,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);
        tbl[8]  = mk(1, 1, 16'h0101,  1, 3, 16'h3333,  1, 0, 16'h0000, 0,  1, 1, 16'h0101);
        tbl[9]  = mk(1, 2, 16'h0202,  0, 0, 16'h0000,  1, 0, 16'h0008, 0,  1, 2, 16'h0202);
        tbl[10] = mk(1, 4, 16'h0404,  0, 0, 16'h0000,  1, 0, 16'h0008, 0,  1, 4, 16'h0404);
        tbl[11] = mk(1, 6, 16'h0606,  0, 0, 16'h0000,  1, 0, 16'h0008, 0,  1, 6, 16'h0606);
        tbl[12] = mk(1, 8, 16'h0808,  0, 0, 16'h0000,  1, 1, 16'h0008, 0,  1, 3, 16'h3333);
        tbl[13] = mk(1, 8, 16'h0808,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  1, 8, 16'h0808);
        tbl[14] = mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000);

        rst = 1'b1;
        idle_inputs();
        #2;
        check_reset_state("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
        end

        // Full FIFO: 4 pushes under continuous pipe traffic, 5th held off until a pop
        apply(mk(1, 1, 16'h0100,  1, 10, 16'hA000,  1, 0, 16'h0000, 0,  1, 1,  16'h0100));
        apply(mk(1, 1, 16'h0101,  1, 11, 16'hA001,  1, 0, 16'h0400, 0,  1, 1,  16'h0101));
        apply(mk(1, 1, 16'h0102,  1, 12, 16'hA002,  1, 0, 16'h0C00, 0,  1, 1,  16'h0102));
        apply(mk(1, 1, 16'h0103,  1, 13, 16'hA003,  1, 0, 16'h1C00, 0,  1, 1,  16'h0103));
        apply(mk(1, 1, 16'h0104,  1, 14, 16'hA004,  0, 1, 16'h3C00, 0,  1, 10, 16'hA000));
        apply(mk(1, 1, 16'h0104,  1, 14, 16'hA004,  1, 0, 16'h3800, 0,  1, 1,  16'h0104));
        apply(mk(0, 0, 16'h0000,  0, 0,  16'h0000,  0, 0, 16'h7800, 0,  1, 11, 16'hA001));
        apply(mk(0, 0, 16'h0000,  0, 0,  16'h0000,  1, 0, 16'h7000, 0,  1, 12, 16'hA002));
        apply(mk(0, 0, 16'h0000,  0, 0,  16'h0000,  1, 0, 16'h6000, 0,  1, 13, 16'hA003));
        apply(mk(0, 0, 16'h0000,  0, 0,  16'h0000,  1, 0, 16'h4000, 0,  1, 14, 16'hA004));
        apply(mk(0, 0, 16'h0000,  0, 0,  16'h0000,  1, 0, 16'h0000, 0,  0, 0,  16'h0000));

        // Hazard: pipe writes R9 while a late R9 write is pending; error is sticky
        apply(mk(0, 0, 16'h0000,  1, 9, 16'h9999,  1, 0, 16'h0000, 0,  0, 0, 16'h0000));
        apply(mk(1, 9, 16'h1111,  0, 0, 16'h0000,  1, 0, 16'h0200, 0,  1, 9, 16'h1111));
        apply(mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0200, 1,  1, 9, 16'h9999));
        apply(mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 1,  0, 0, 16'h0000));
        apply(mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 1,  0, 0, 16'h0000));

        // Async reset with two entries buffered and a write in flight
        apply(mk(1, 1, 16'h0010,  1, 2, 16'h2222,  1, 0, 16'h0000, 1,  1, 1, 16'h0010));
        apply(mk(1, 1, 16'h0011,  1, 5, 16'h5555,  1, 0, 16'h0004, 1,  1, 1, 16'h0011));
        apply(mk(1, 1, 16'h0012,  0, 0, 16'h0000,  1, 0, 16'h0024, 1,  1, 1, 16'h0012));
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check("rst_hold_rf_we", rf_we, 1'b0);
        #1 rst = 1'b0;
        last_a = 4'd0;
        last_d = 16'd0;
        apply(mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000));
        apply(mk(1, 5, 16'h00AA,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  1, 5, 16'h00AA));
        apply(mk(0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0, 16'h0000, 0,  0, 0, 16'h0000));

        check("scoreboard_drained", exq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
